// File: rtl/wavetable_voice.sv
// rtl/wavetable_voice.sv - RAM-loadable wavetable voice with looped/one-shot playback
module wavetable_voice #(
    parameter int SAMPLE_W = 32,
    parameter int SEG_AW   = 6,
    parameter int PERIOD_W = 32
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       play_note,
    input  logic                       loop_en,
    input  logic [PERIOD_W-1:0]        hz,
    input  logic [3:0]                 atten,
    input  logic                       wr_en,
    input  logic [SEG_AW-1:0]          wr_addr,
    input  logic signed [SAMPLE_W-1:0] wr_data,
    output logic signed [SAMPLE_W-1:0] audio_out,
    output logic                       busy,
    output logic                       period_done
);

    localparam int SEG_COUNT = 1 << SEG_AW;
    localparam logic [SEG_AW-1:0] LAST_SEG = SEG_AW'(SEG_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic                        play_q;
    logic                        armed_q;
    logic [SEG_AW-1:0]           seg_idx_q, seg_idx_d;
    logic [PERIOD_W-1:0]         seg_cnt_q, seg_cnt_d;
    logic [PERIOD_W-1:0]         seg_len_q, seg_len_d;
    logic signed [SAMPLE_W-1:0]  audio_q, audio_d;
    logic                        done_q, done_d;
    logic signed [SAMPLE_W-1:0]  table_q [SEG_COUNT];

    logic                        rise;
    logic [PERIOD_W-1:0]         hz_len;

    // Segment length from the note period; periods shorter than one cycle per segment clamp to 1.
    always_comb begin
        hz_len = hz >> SEG_AW;
        if (hz_len == '0) begin
            hz_len = PERIOD_W'(1);
        end
    end

    // armed_q masks the first cycle after reset so a key held through reset does not start a note.
    assign rise = play_note & ~play_q & armed_q;

    always_comb begin
        state_d   = state_q;
        seg_idx_d = seg_idx_q;
        seg_cnt_d = seg_cnt_q;
        seg_len_d = seg_len_q;
        done_d    = 1'b0;

        if ((state_q != PLAY) && rise) begin
            state_d   = PLAY;
            seg_len_d = hz_len;
            seg_idx_d = '0;
            seg_cnt_d = hz_len - PERIOD_W'(1);
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                PLAY: begin
                    if (!play_note) begin
                        state_d = IDLE;
                    end else if (seg_cnt_q != '0) begin
                        seg_cnt_d = seg_cnt_q - PERIOD_W'(1);
                    end else if (seg_idx_q != LAST_SEG) begin
                        seg_idx_d = seg_idx_q + SEG_AW'(1);
                        seg_cnt_d = seg_len_q - PERIOD_W'(1);
                    end else begin
                        done_d = 1'b1;
                        if (loop_en) begin
                            seg_idx_d = '0;
                            seg_len_d = hz_len;
                            seg_cnt_d = hz_len - PERIOD_W'(1);
                        end else begin
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!play_note) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        audio_d = '0;
        if (state_q == PLAY) begin
            audio_d = table_q[seg_idx_q] >>> atten;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            play_q    <= 1'b0;
            armed_q   <= 1'b0;
            seg_idx_q <= '0;
            seg_cnt_q <= '0;
            seg_len_q <= PERIOD_W'(1);
            audio_q   <= '0;
            done_q    <= 1'b0;
            for (int i = 0; i < SEG_COUNT; i++) begin
                table_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            play_q    <= play_note;
            armed_q   <= 1'b1;
            seg_idx_q <= seg_idx_d;
            seg_cnt_q <= seg_cnt_d;
            seg_len_q <= seg_len_d;
            audio_q   <= audio_d;
            done_q    <= done_d;
            if (wr_en) begin
                table_q[wr_addr] <= wr_data;
            end
        end
    end

    assign audio_out   = audio_q;
    assign busy        = (state_q == PLAY);
    assign period_done = done_q;

endmodule

// File: tb/tb_wavetable_voice.sv
// tb/tb_wavetable_voice.sv - self-checking bench for wavetable_voice against a period-position model
module tb_wavetable_voice;

    logic               clock = 1'b0;
    logic               reset_n;
    logic               play_note;
    logic               loop_en;
    logic [31:0]        hz;
    logic [3:0]         atten;
    logic               wr_en;
    logic [5:0]         wr_addr;
    logic signed [31:0] wr_data;
    logic signed [31:0] audio_out;
    logic               busy;
    logic               period_done;

    wavetable_voice #(.SAMPLE_W(32), .SEG_AW(6), .PERIOD_W(32)) dut (
        .clock(clock), .reset_n(reset_n), .play_note(play_note), .loop_en(loop_en),
        .hz(hz), .atten(atten), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .audio_out(audio_out), .busy(busy), .period_done(period_done)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int tick_n = 0;

    // Model: a note is a position within the current period plus its segment length.
    logic signed [31:0] m_tab [64];
    bit                 m_play, m_hold, m_prev, m_armed;
    longint             m_pos, m_len;
    logic signed [31:0] e_audio;
    bit                 e_busy, e_done;

    int aud [0:800];
    int done_at [$];

    function automatic longint len_of(logic [31:0] h);
        longint s;
        s = longint'(h) / 64;
        return (s == 0) ? 1 : s;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_tab[i] = 0;
        m_play = 0; m_hold = 0; m_prev = 0; m_armed = 0;
        m_pos = 0; m_len = 1;
        e_audio = 0; e_busy = 0; e_done = 0;
    endtask

    task automatic tick();
        logic signed [31:0] na;
        @(posedge clock);
        na = m_play ? (m_tab[int'(m_pos / m_len)] >>> atten) : 32'sd0;
        e_done = 0;
        if (m_play) begin
            if (!play_note) m_play = 0;
            else if (m_pos == 64 * m_len - 1) begin
                e_done = 1;
                if (loop_en) begin m_pos = 0; m_len = len_of(hz); end
                else begin m_play = 0; m_hold = 1; end
            end else m_pos++;
        end else if (m_hold) begin
            if (!play_note) m_hold = 0;
        end else if (play_note && !m_prev && m_armed) begin
            m_play = 1; m_pos = 0; m_len = len_of(hz);
        end
        m_prev = play_note;
        m_armed = 1;
        if (wr_en) m_tab[wr_addr] = wr_data;
        e_audio = na;
        e_busy = m_play;
        tick_n++;
        #1;
    endtask

    task automatic write_tab(input int a, input int d);
        wr_en = 1; wr_addr = 6'(a); wr_data = d;
        tick();
        wr_en = 0;
    endtask

    task automatic idle_ticks(input int n);
        play_note = 0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        reset_n = 0; play_note = 0; loop_en = 0; hz = 0; atten = 0;
        wr_en = 0; wr_addr = 0; wr_data = 0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if ({audio_out, busy, period_done} !== 34'd0) begin
            errors++;
            $display("FAIL reset_state audio=%0d busy=%b done=%b required 0 0 0", audio_out, busy, period_done);
        end
        reset_n = 1;
        idle_ticks(2);
    endtask

    task automatic test_oneshot();
        int t0;
        write_tab(0, 100);
        write_tab(1, -200);
        hz = 128; loop_en = 0; atten = 0; play_note = 1;
        done_at.delete();
        t0 = tick_n;
        for (int i = 0; i < 140; i++) begin
            tick();
            aud[tick_n - t0] = audio_out;
            if (period_done) done_at.push_back(tick_n - t0);
            checks++;
            if ({audio_out, busy, period_done} !== {e_audio, e_busy, e_done}) begin
                errors++;
                $display("FAIL oneshot_cycle r=%0d audio=%0d busy=%b done=%b required %0d %b %b",
                         tick_n - t0, audio_out, busy, period_done, e_audio, e_busy, e_done);
            end
        end
        checks++;
        if (aud[2] !== 100 || aud[3] !== 100 || aud[4] !== -200 || aud[5] !== -200 || aud[6] !== 0) begin
            errors++;
            $display("FAIL oneshot_pattern got %0d %0d %0d %0d %0d required 100 100 -200 -200 0",
                     aud[2], aud[3], aud[4], aud[5], aud[6]);
        end
        checks++;
        if (done_at.size() != 1 || done_at[0] != 129) begin
            errors++;
            $display("FAIL oneshot_done count=%0d first=%0d required 1 pulse at 129",
                     done_at.size(), (done_at.size() > 0) ? done_at[0] : -1);
        end
        checks++;
        if (busy !== 1'b0 || audio_out !== 0) begin
            errors++;
            $display("FAIL oneshot_hold busy=%b audio=%0d required 0 0", busy, audio_out);
        end
        idle_ticks(2);
    endtask

    task automatic test_loop();
        int t0;
        hz = 128; loop_en = 1; atten = 0; play_note = 1;
        done_at.delete();
        t0 = tick_n;
        for (int i = 0; i < 700; i++) begin
            if (tick_n - t0 == 280) hz = 256;
            tick();
            aud[tick_n - t0] = audio_out;
            if (period_done) done_at.push_back(tick_n - t0);
            checks++;
            if ({audio_out, busy, period_done} !== {e_audio, e_busy, e_done}) begin
                errors++;
                $display("FAIL loop_cycle r=%0d audio=%0d busy=%b done=%b required %0d %b %b",
                         tick_n - t0, audio_out, busy, period_done, e_audio, e_busy, e_done);
            end
        end
        checks++;
        if (done_at.size() != 4 || done_at[0] != 129 || done_at[1] != 257 ||
            done_at[2] != 385 || done_at[3] != 641) begin
            errors++;
            $display("FAIL loop_done count=%0d required 4 pulses at 129 257 385 641", done_at.size());
        end
        checks++;
        if (aud[130] !== 100 || aud[132] !== -200 || aud[389] !== 100 || aud[390] !== -200) begin
            errors++;
            $display("FAIL loop_restart got %0d %0d %0d %0d required 100 -200 100 -200",
                     aud[130], aud[132], aud[389], aud[390]);
        end
        idle_ticks(2);
    endtask

    task automatic test_atten();
        int t0;
        hz = 128; loop_en = 0; atten = 2; play_note = 1;
        t0 = tick_n;
        for (int i = 0; i < 6; i++) begin
            tick();
            aud[tick_n - t0] = audio_out;
            checks++;
            if (audio_out !== e_audio) begin
                errors++;
                $display("FAIL atten2_cycle r=%0d audio=%0d required %0d", tick_n - t0, audio_out, e_audio);
            end
        end
        checks++;
        if (aud[2] !== 25 || aud[4] !== -50) begin
            errors++;
            $display("FAIL atten2_value got %0d %0d required 25 -50", aud[2], aud[4]);
        end
        idle_ticks(2);
        atten = 15; play_note = 1;
        t0 = tick_n;
        for (int i = 0; i < 4; i++) begin
            tick();
            aud[tick_n - t0] = audio_out;
        end
        checks++;
        if (aud[2] !== 0 || aud[4] !== -1) begin
            errors++;
            $display("FAIL atten15_value got %0d %0d required 0 -1", aud[2], aud[4]);
        end
        atten = 0;
        idle_ticks(2);
    endtask

    task automatic test_short_hz();
        int t0;
        logic [31:0] hzs [2];
        hzs[0] = 10; hzs[1] = 0;
        for (int k = 0; k < 2; k++) begin
            hz = hzs[k]; loop_en = 1; play_note = 1;
            done_at.delete();
            t0 = tick_n;
            for (int i = 0; i < 140; i++) begin
                tick();
                aud[tick_n - t0] = audio_out;
                if (period_done) done_at.push_back(tick_n - t0);
                checks++;
                if ({audio_out, busy, period_done} !== {e_audio, e_busy, e_done}) begin
                    errors++;
                    $display("FAIL short_hz_cycle hz=%0d r=%0d audio=%0d done=%b required %0d %b",
                             hz, tick_n - t0, audio_out, period_done, e_audio, e_done);
                end
            end
            checks++;
            if (done_at.size() != 2 || done_at[0] != 65 || done_at[1] != 129 ||
                aud[2] !== 100 || aud[3] !== -200 || aud[4] !== 0) begin
                errors++;
                $display("FAIL short_hz_period hz=%0d pulses=%0d samples %0d %0d %0d required 2 at 65 129, 100 -200 0",
                         hz, done_at.size(), aud[2], aud[3], aud[4]);
            end
            idle_ticks(2);
        end
    endtask

    task automatic test_release();
        int  guard;
        bit  saw_done;
        write_tab(2, 300);
        hz = 128; loop_en = 0; play_note = 1;
        tick();
        for (int i = 0; i < 4; i++) tick();
        play_note = 0;
        tick();
        checks++;
        if (busy !== 1'b0 || audio_out !== 300 || e_busy !== 0) begin
            errors++;
            $display("FAIL release_mid busy=%b audio=%0d required 0 300", busy, audio_out);
        end
        tick();
        checks++;
        if (audio_out !== 0) begin
            errors++;
            $display("FAIL release_mid_silence audio=%0d required 0", audio_out);
        end
        tick();
        play_note = 1;
        guard = 0;
        tick();
        while (!(m_play && m_pos == 64 * m_len - 1) && guard < 300) begin
            tick();
            guard++;
        end
        checks++;
        if (guard >= 300) begin
            errors++;
            $display("FAIL release_last_wait timed out after %0d cycles required < 300", guard);
        end
        play_note = 0;
        saw_done = 0;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL release_last_busy busy=%b required 0", busy);
        end
        if (period_done) saw_done = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (period_done) saw_done = 1;
        end
        checks++;
        if (saw_done || audio_out !== 0) begin
            errors++;
            $display("FAIL release_last_nopulse done_seen=%b audio=%0d required 0 0", saw_done, audio_out);
        end
    endtask

    task automatic test_random();
        int n;
        for (int note = 0; note < 5; note++) begin
            for (int a = 0; a < 64; a++) write_tab(a, int'($urandom()));
            hz = $urandom_range(0, 400);
            loop_en = 1'($urandom_range(0, 1));
            atten = 4'($urandom_range(0, 15));
            play_note = 1;
            n = $urandom_range(50, 400);
            for (int i = 0; i < n; i++) begin
                wr_en = ($urandom_range(0, 3) == 0);
                wr_addr = 6'($urandom_range(0, 63));
                wr_data = int'($urandom());
                if ($urandom_range(0, 15) == 0) atten = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 31) == 0) hz = $urandom_range(0, 400);
                tick();
                checks++;
                if ({audio_out, busy, period_done} !== {e_audio, e_busy, e_done}) begin
                    errors++;
                    $display("FAIL random_cycle note=%0d i=%0d audio=%0d busy=%b done=%b required %0d %b %b",
                             note, i, audio_out, busy, period_done, e_audio, e_busy, e_done);
                end
            end
            wr_en = 0;
            idle_ticks(3);
        end
    endtask

    task automatic test_async_reset();
        bit saw_busy;
        bit bad_audio;
        write_tab(0, 100);
        hz = 128; loop_en = 1; atten = 0; play_note = 1;
        for (int i = 0; i < 10; i++) tick();
        #2;
        reset_n = 0;
        #1;
        checks++;
        if ({audio_out, busy, period_done} !== 34'd0) begin
            errors++;
            $display("FAIL async_reset audio=%0d busy=%b done=%b required 0 0 0", audio_out, busy, period_done);
        end
        model_reset();
        @(posedge clock);
        #1;
        reset_n = 1;
        saw_busy = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (busy) saw_busy = 1;
        end
        checks++;
        if (saw_busy) begin
            errors++;
            $display("FAIL held_key_after_reset busy_seen=%b required 0", saw_busy);
        end
        idle_ticks(2);
        play_note = 1; loop_en = 0;
        saw_busy = 0; bad_audio = 0;
        for (int i = 0; i < 140; i++) begin
            tick();
            if (busy) saw_busy = 1;
            if (audio_out !== 0) bad_audio = 1;
            checks++;
            if ({audio_out, busy, period_done} !== {e_audio, e_busy, e_done}) begin
                errors++;
                $display("FAIL post_reset_cycle i=%0d audio=%0d busy=%b done=%b required %0d %b %b",
                         i, audio_out, busy, period_done, e_audio, e_busy, e_done);
            end
        end
        checks++;
        if (!saw_busy || bad_audio) begin
            errors++;
            $display("FAIL post_reset_table busy_seen=%b nonzero_audio=%b required 1 0", saw_busy, bad_audio);
        end
        idle_ticks(2);
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_loop();
        test_atten();
        test_short_hz();
        test_release();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
